// File: rtl/axi_split_4kb_ctrl.sv
// axi_split_4kb_ctrl
//   Splits an AXI address-channel request that crosses a 4 KB boundary into
//   two sub-requests. Requests that stay within one page pass through as a
//   single sub-request. A per-transaction "was split" flag is queued in a
//   small FIFO so a downstream response merger knows how many responses to
//   fold back into one.
//
// Ports
//   ACLK_i, ARESETn_i             clock (rising), async active-low reset
//   AxID_i/AxADDR_i/AxLEN_i/AxSIZE_i, AxVALID_i, AxREADY_o
//                                 upstream request channel
//   AxID_o/AxADDR_o/AxLEN_o/AxSIZE_o, AxVALID_o, AxREADY_i
//                                 downstream sub-request channel
//   split_info_o                  1 = head transaction was split into two
//   split_info_valid_o            split-info FIFO not empty
//   split_info_ready_i            consumer pops the head entry
//   split_cnt_o (16b)             only with SPLIT_4KB_CNT_EN: saturating
//                                 count of accepted requests that were split
//
// Build option
//   SPLIT_4KB_CNT_EN              adds split_cnt_o and its counter
//
// Downstream outputs come from registered request fields and the FSM state
// only, so there is no combinational path from the upstream channel.

module axi_split_4kb_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 5,
  parameter int LEN_WIDTH  = 8,
  parameter int SIZE_WIDTH = 3,
  parameter int INFO_DEPTH = 4
) (
  input  logic                  ACLK_i,
  input  logic                  ARESETn_i,
  input  logic [ID_WIDTH-1:0]   AxID_i,
  input  logic [ADDR_WIDTH-1:0] AxADDR_i,
  input  logic [LEN_WIDTH-1:0]  AxLEN_i,
  input  logic [SIZE_WIDTH-1:0] AxSIZE_i,
  input  logic                  AxVALID_i,
  output logic                  AxREADY_o,
  output logic [ID_WIDTH-1:0]   AxID_o,
  output logic [ADDR_WIDTH-1:0] AxADDR_o,
  output logic [LEN_WIDTH-1:0]  AxLEN_o,
  output logic [SIZE_WIDTH-1:0] AxSIZE_o,
  output logic                  AxVALID_o,
  input  logic                  AxREADY_i,
  output logic                  split_info_o,
  output logic                  split_info_valid_o,
  input  logic                  split_info_ready_i
`ifdef SPLIT_4KB_CNT_EN
  ,
  output logic [15:0]           split_cnt_o
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND_1ST = 2'd1;
  localparam logic [1:0] SEND_2ND = 2'd2;

  localparam int PTR_W   = $clog2(INFO_DEPTH);
  // (LEN+1) needs LEN_WIDTH+1 bits; the largest shift adds 2**SIZE_WIDTH-1.
  localparam int BYTES_W = LEN_WIDTH + 2**SIZE_WIDTH;
  localparam int SUM_W   = BYTES_W + 1;
  localparam int PG_W    = ADDR_WIDTH - 12;

  // Offset within the page with the sub-beat bits cleared.
  function automatic logic [11:0] off_f(input logic [11:0] a,
                                        input logic [SIZE_WIDTH-1:0] s);
    logic [11:0] mask;
    mask  = (12'd1 << s) - 12'd1;
    off_f = a & ~mask;
  endfunction

  // Sum is carried wide enough that oversized bursts still compare correctly.
  function automatic logic cross_f(input logic [11:0] a,
                                   input logic [LEN_WIDTH-1:0] l,
                                   input logic [SIZE_WIDTH-1:0] s);
    logic [BYTES_W-1:0] bytes;
    logic [SUM_W-1:0]   fin;
    bytes   = (BYTES_W'(l) + BYTES_W'(1)) << s;
    fin     = SUM_W'(off_f(a, s)) + SUM_W'(bytes);
    cross_f = fin > SUM_W'(4096);
  endfunction

  logic [1:0]            state_q;
  logic                  rst_done_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [SIZE_WIDTH-1:0] size_q;

  logic [INFO_DEPTH-1:0] info_mem;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        info_cnt;
  logic                  info_full;

  logic                  up_hs, dn_hs, push, pop, in_cross;
  logic                  cross_q;
  logic [12:0]           room;
  logic [LEN_WIDTH-1:0]  len1, len2;
  logic [PG_W-1:0]       page_nxt;

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  assign info_full = (info_cnt == (PTR_W+1)'(INFO_DEPTH));
  assign AxREADY_o = (state_q == IDLE) & ~info_full & rst_done_q;
  assign AxVALID_o = (state_q != IDLE);
  assign up_hs     = AxVALID_i & AxREADY_o;
  assign dn_hs     = AxVALID_o & AxREADY_i;

  // The FIFO entry is written in the accept cycle, so the flag has to be
  // derived from the incoming fields rather than the (not yet loaded) regs.
  assign in_cross  = cross_f(AxADDR_i[11:0], AxLEN_i, AxSIZE_i);
  assign push      = up_hs;
  assign pop       = split_info_valid_o & split_info_ready_i;

  // ---------------------------------------------------------------------
  // Split math on the registered request
  // ---------------------------------------------------------------------
  assign cross_q  = cross_f(addr_q[11:0], len_q, size_q);
  assign room     = 13'd4096 - {1'b0, off_f(addr_q[11:0], size_q)};
  assign len1     = LEN_WIDTH'((room >> size_q) - 13'd1);
  assign len2     = len_q - len1 - LEN_WIDTH'(1);
  // Carry out of the top page is dropped: the second half wraps to 0.
  assign page_nxt = addr_q[ADDR_WIDTH-1:12] + PG_W'(1);

  assign AxID_o   = id_q;
  assign AxSIZE_o = size_q;
  assign AxADDR_o = (state_q == SEND_2ND) ? {page_nxt, 12'h000} : addr_q;
  assign AxLEN_o  = (state_q == SEND_2ND) ? len2 : (cross_q ? len1 : len_q);

  // ---------------------------------------------------------------------
  // FSM + request registers
  // ---------------------------------------------------------------------
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_q    <= IDLE;
      rst_done_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
    end else begin
      rst_done_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (up_hs) begin
            id_q    <= AxID_i;
            addr_q  <= AxADDR_i;
            len_q   <= AxLEN_i;
            size_q  <= AxSIZE_i;
            state_q <= SEND_1ST;
          end
        end
        SEND_1ST: begin
          if (dn_hs) state_q <= cross_q ? SEND_2ND : IDLE;
        end
        SEND_2ND: begin
          if (dn_hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Split-info FIFO (no bypass: a full FIFO simply holds off AxREADY_o)
  // ---------------------------------------------------------------------
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      info_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      info_cnt <= '0;
    end else begin
      if (push) begin
        info_mem[wr_ptr] <= in_cross;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   info_cnt <= info_cnt + (PTR_W+1)'(1);
        2'b01:   info_cnt <= info_cnt - (PTR_W+1)'(1);
        default: info_cnt <= info_cnt;
      endcase
    end
  end

  assign split_info_valid_o = (info_cnt != '0);
  assign split_info_o       = info_mem[rd_ptr];

`ifdef SPLIT_4KB_CNT_EN
  // ---------------------------------------------------------------------
  // Saturating split counter
  // ---------------------------------------------------------------------
  logic [15:0] split_cnt_q;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i)
      split_cnt_q <= '0;
    else if (push && in_cross && (split_cnt_q != 16'hFFFF))
      split_cnt_q <= split_cnt_q + 16'd1;
  end

  assign split_cnt_o = split_cnt_q;
`endif

endmodule

// File: tb/tb_axi_split_4kb_ctrl.sv
// Scoreboard bench for axi_split_4kb_ctrl: stimulus pushes expected
// sub-requests and split flags into queues; monitors pop and compare.
module tb_axi_split_4kb_ctrl;

  logic        ACLK_i = 1'b0;
  logic        ARESETn_i;
  logic [4:0]  AxID_i;
  logic [31:0] AxADDR_i;
  logic [7:0]  AxLEN_i;
  logic [2:0]  AxSIZE_i;
  logic        AxVALID_i;
  logic        AxREADY_o;
  logic [4:0]  AxID_o;
  logic [31:0] AxADDR_o;
  logic [7:0]  AxLEN_o;
  logic [2:0]  AxSIZE_o;
  logic        AxVALID_o;
  logic        AxREADY_i = 1'b0;
  logic        split_info_o;
  logic        split_info_valid_o;
  logic        split_info_ready_i = 1'b0;
`ifdef SPLIT_4KB_CNT_EN
  logic [15:0] split_cnt_o;
`endif

  axi_split_4kb_ctrl dut (
    .ACLK_i(ACLK_i), .ARESETn_i(ARESETn_i),
    .AxID_i(AxID_i), .AxADDR_i(AxADDR_i), .AxLEN_i(AxLEN_i), .AxSIZE_i(AxSIZE_i),
    .AxVALID_i(AxVALID_i), .AxREADY_o(AxREADY_o),
    .AxID_o(AxID_o), .AxADDR_o(AxADDR_o), .AxLEN_o(AxLEN_o), .AxSIZE_o(AxSIZE_o),
    .AxVALID_o(AxVALID_o), .AxREADY_i(AxREADY_i),
    .split_info_o(split_info_o), .split_info_valid_o(split_info_valid_o),
    .split_info_ready_i(split_info_ready_i)
`ifdef SPLIT_4KB_CNT_EN
    , .split_cnt_o(split_cnt_o)
`endif
  );

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } sub_t;

  sub_t sub_q[$];
  bit   info_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;
  bit   rdy_rand = 1'b1, rdy_force = 1'b1;
  bit   irdy_rand = 1'b1, irdy_force = 1'b1;

  always #5 ACLK_i = ~ACLK_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready drivers: random or forced, applied just after the rising edge.
  initial forever begin
    @(posedge ACLK_i); #1;
    AxREADY_i          = rdy_rand  ? ($urandom_range(0, 3) != 0) : rdy_force;
    split_info_ready_i = irdy_rand ? ($urandom_range(0, 2) != 0) : irdy_force;
  end

  // Reference model: split purely from page arithmetic.
  task automatic model_push(input logic [4:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size);
    int   off, bytes, b1;
    sub_t s;
    off   = int'(addr[11:0]) & ~((1 << size) - 1);
    bytes = (int'(len) + 1) << size;
    if (off + bytes > 4096) begin
      b1 = (4096 - off) >> size;
      s = '{id, addr, 8'(b1 - 1), size};
      sub_q.push_back(s);
      s = '{id, (addr & 32'hFFFF_F000) + 32'h0000_1000, 8'(int'(len) - b1), size};
      sub_q.push_back(s);
      info_q.push_back(1'b1);
      exp_cnt++;
    end else begin
      s = '{id, addr, len, size};
      sub_q.push_back(s);
      info_q.push_back(1'b0);
    end
  endtask

  // Downstream monitor: ordering, contents, hold-while-stalled, busy ready.
  initial begin
    sub_t prev, cur, e;
    bit   prev_hold;
    prev_hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge ACLK_i);
      if (!ARESETn_i) begin
        prev_hold = 1'b0;
      end else begin
        cur = '{AxID_o, AxADDR_o, AxLEN_o, AxSIZE_o};
        if (prev_hold) begin
          chk("hold_valid", 64'(AxVALID_o), 64'd1);
          chk("hold_fields", 64'(cur), 64'(prev));
        end
        if (AxVALID_o) chk("busy_ready_low", 64'(AxREADY_o), 64'd0);
        if (AxVALID_o && AxREADY_i) begin
          if (sub_q.size() == 0) begin
            chk("unexpected_subreq", 64'(cur), 64'hDEAD);
          end else begin
            e = sub_q.pop_front();
            chk("subreq", 64'(cur), 64'(e));
          end
        end
        prev_hold = AxVALID_o && !AxREADY_i;
        prev = cur;
      end
    end
  end

  // Split-info monitor.
  initial begin
    bit e;
    forever begin
      @(negedge ACLK_i);
      if (ARESETn_i && split_info_valid_o && split_info_ready_i) begin
        if (info_q.size() == 0) begin
          chk("unexpected_info", 64'(split_info_o), 64'd2);
        end else begin
          e = info_q.pop_front();
          chk("split_info", 64'(split_info_o), 64'(e));
        end
      end
    end
  end

  // Caller must be between edges (normally at a falling edge).
  task automatic send_req(input logic [4:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input bit directed);
    int n;
    n = 0;
    if (!directed) model_push(id, addr, len, size);
    AxID_i = id; AxADDR_i = addr; AxLEN_i = len; AxSIZE_i = size;
    AxVALID_i = 1'b1;
    while (!AxREADY_o && n < 400) begin
      @(negedge ACLK_i);
      n++;
    end
    if (!AxREADY_o) begin
      chk("accept_timeout", 64'(AxREADY_o), 64'd1);
      AxVALID_i = 1'b0;
      return;
    end
    @(posedge ACLK_i); #1;
    AxVALID_i = 1'b0;
    AxID_i = 5'($urandom); AxADDR_i = $urandom; AxLEN_i = 8'($urandom); AxSIZE_i = 3'($urandom);
    @(negedge ACLK_i);
    chk("latency_valid", 64'(AxVALID_o), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge ACLK_i);
    while (AxVALID_o && n < 400) begin
      @(negedge ACLK_i);
      n++;
    end
    if (AxVALID_o) chk("idle_timeout", 64'(AxVALID_o), 64'd0);
  endtask

  task automatic push_exp(input logic [4:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
    sub_t s;
    s = '{id, addr, len, size};
    sub_q.push_back(s);
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #500000;
    chk("watchdog", 64'd1, 64'd0);
    summary();
    $finish;
  end

  initial begin
    bit   saw;
    int   n, len_i, size_i;
    logic [31:0] a;

    ARESETn_i = 1'b0; AxVALID_i = 1'b0;
    AxID_i = '0; AxADDR_i = '0; AxLEN_i = '0; AxSIZE_i = '0;
    #2;
    chk("rst_valid", 64'(AxVALID_o), 64'd0);
    chk("rst_ready", 64'(AxREADY_o), 64'd0);
    chk("rst_info_valid", 64'(split_info_valid_o), 64'd0);
    chk("rst_data", 64'({AxID_o, AxADDR_o, AxLEN_o, AxSIZE_o, split_info_o}), 64'd0);
    repeat (3) @(posedge ACLK_i);
    @(negedge ACLK_i);
    ARESETn_i = 1'b1;
    #1 chk("ready_before_first_edge", 64'(AxREADY_o), 64'd0);
    @(negedge ACLK_i);
    chk("ready_after_reset", 64'(AxREADY_o), 64'd1);

    // Directed: page-aligned, crossing, ends exactly on boundary, top-page wrap.
    push_exp(5'd3, 32'h0000_1000, 8'd3, 3'd2); info_q.push_back(1'b0);
    send_req(5'd3, 32'h0000_1000, 8'd3, 3'd2, 1'b1);
    push_exp(5'd4, 32'h0000_0FF0, 8'd3, 3'd2);
    push_exp(5'd4, 32'h0000_1000, 8'd3, 3'd2); info_q.push_back(1'b1); exp_cnt++;
    send_req(5'd4, 32'h0000_0FF0, 8'd7, 3'd2, 1'b1);
    push_exp(5'd5, 32'h0000_0FE0, 8'd7, 3'd2); info_q.push_back(1'b0);
    send_req(5'd5, 32'h0000_0FE0, 8'd7, 3'd2, 1'b1);
    push_exp(5'd6, 32'hFFFF_FFF0, 8'd3, 3'd2);
    push_exp(5'd6, 32'h0000_0000, 8'd3, 3'd2); info_q.push_back(1'b1); exp_cnt++;
    send_req(5'd6, 32'hFFFF_FFF0, 8'd7, 3'd2, 1'b1);

    // Crossing request with 5-cycle downstream stalls in each send state.
    wait_idle();
    rdy_rand = 1'b0; rdy_force = 1'b0;
    @(negedge ACLK_i);
    push_exp(5'd7, 32'h0000_0FF0, 8'd3, 3'd2);
    push_exp(5'd7, 32'h0000_1000, 8'd3, 3'd2); info_q.push_back(1'b1); exp_cnt++;
    send_req(5'd7, 32'h0000_0FF0, 8'd7, 3'd2, 1'b1);
    repeat (5) @(negedge ACLK_i);
    rdy_force = 1'b1;
    @(negedge ACLK_i);
    rdy_force = 1'b0;
    repeat (6) @(negedge ACLK_i);
    chk("stall_2nd_addr", 64'(AxADDR_o), 64'h1000);
    rdy_force = 1'b1;
    wait_idle();
    rdy_rand = 1'b1;

    // Split-info FIFO fills: 4 accepted, 5th stalls until a pop.
    wait_idle();
    irdy_rand = 1'b0; irdy_force = 1'b1;
    n = 0;
    while (split_info_valid_o && n < 200) begin @(negedge ACLK_i); n++; end
    irdy_force = 1'b0; rdy_rand = 1'b0; rdy_force = 1'b1;
    repeat (2) @(negedge ACLK_i);
    for (int i = 0; i < 4; i++)
      send_req(5'(10 + i), 32'h0000_2000 + 32'(i * 16'h0F80), 8'd7, 3'd2, 1'b0);
    AxID_i = 5'd20; AxADDR_i = 32'h0000_5FF8; AxLEN_i = 8'd3; AxSIZE_i = 3'd2;
    AxVALID_i = 1'b1;
    saw = 1'b0;
    repeat (10) begin @(negedge ACLK_i); saw |= AxREADY_o; end
    chk("fifo_full_stall", 64'(saw), 64'd0);
    chk("fifo_full_info_valid", 64'(split_info_valid_o), 64'd1);
    irdy_force = 1'b1;
    send_req(5'd20, 32'h0000_5FF8, 8'd3, 3'd2, 1'b0);
    irdy_rand = 1'b1; rdy_rand = 1'b1;

    // Reset during the second sub-request.
    wait_idle();
    rdy_rand = 1'b0; rdy_force = 1'b0;
    @(negedge ACLK_i);
    push_exp(5'd9, 32'h0000_0FF0, 8'd3, 3'd2);
    push_exp(5'd9, 32'h0000_1000, 8'd3, 3'd2); info_q.push_back(1'b1); exp_cnt++;
    send_req(5'd9, 32'h0000_0FF0, 8'd7, 3'd2, 1'b1);
    rdy_force = 1'b1;
    @(negedge ACLK_i);
    rdy_force = 1'b0;
    @(posedge ACLK_i); #3;
    chk("in_send2_valid", 64'(AxVALID_o), 64'd1);
    chk("in_send2_addr", 64'(AxADDR_o), 64'h1000);
    ARESETn_i = 1'b0;
    sub_q.delete(); info_q.delete(); exp_cnt = 0;
    #1;
    chk("mid_rst_valid", 64'(AxVALID_o), 64'd0);
    chk("mid_rst_ready", 64'(AxREADY_o), 64'd0);
    chk("mid_rst_info_valid", 64'(split_info_valid_o), 64'd0);
    chk("mid_rst_data", 64'({AxID_o, AxADDR_o, AxLEN_o, AxSIZE_o}), 64'd0);
`ifdef SPLIT_4KB_CNT_EN
    chk("mid_rst_cnt", 64'(split_cnt_o), 64'd0);
`endif
    repeat (2) @(negedge ACLK_i);
    rdy_force = 1'b1;
    ARESETn_i = 1'b1;
    #1 chk("rel_ready_low", 64'(AxREADY_o), 64'd0);
    @(negedge ACLK_i);
    chk("rel_ready_one_cycle", 64'(AxREADY_o), 64'd1);
    saw = 1'b0;
    repeat (5) begin @(negedge ACLK_i); saw |= AxVALID_o; end
    chk("no_second_sub", 64'(saw), 64'd0);
    rdy_rand = 1'b1;

    // Randomized traffic, biased toward page ends and the top page.
    for (int i = 0; i < 60; i++) begin
      size_i = $urandom_range(0, 4);
      len_i  = $urandom_range(0, 255);
      while (((len_i + 1) << size_i) > 4096) len_i = len_i >> 1;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[11:8] = 4'hF;
      if ($urandom_range(0, 7) == 0) a[31:12] = 20'hFFFFF;
      send_req(5'($urandom), a, 8'(len_i), 3'(size_i), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge ACLK_i);
    end

    n = 0;
    while ((sub_q.size() != 0 || info_q.size() != 0) && n < 1000) begin
      @(negedge ACLK_i); n++;
    end
    chk("drain_subreq", 64'(sub_q.size()), 64'd0);
    chk("drain_info", 64'(info_q.size()), 64'd0);
`ifdef SPLIT_4KB_CNT_EN
    chk("split_cnt", 64'(split_cnt_o), 64'(exp_cnt));
`endif
    summary();
    $finish;
  end

endmodule
